psg_bus_master: RTL
===================

# psg_bus_master

Bus initiator for the YM2149/AY-3-8910 register interface. It turns a simple valid/ready register request (address, write data, read/write) into the chip's BDIR/BC bus cycles: an address-latch phase, then a data-write or data-read phase, each followed by an idle gap. It sits between the host core (CPU glue or a sound-command sequencer) and the `ym2149` responder. It hides the edge-triggered latch protocol and can optionally skip redundant address phases.

## Interface
- PULSE_LEN, 2, cycles each active bus phase (address, write, read) is held; legal range 1..15
- GAP_LEN, 1, idle (BDIR=0, BC=0) cycles after each active phase; legal range 1..15. Must be ≥1 so that every BDIR assertion starts with a rising edge.
- ADDR_CACHE, 1, when 1, the address phase is skipped if the register number equals the last latched one

- CLK  in  1  global clock
- RESET  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block idle, accepts a request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  4  PSG register number
- req_wdata  in  8  write data
- rd_valid  out  1  one-cycle pulse: rd_data is valid
- rd_data  out  8  captured read data; holds until the next read
- BDIR  out  1  to PSG BDIR
- BC  out  1  to PSG BC
- bus_do  out  8  to PSG DI
- bus_di  in  8  from PSG DO

## Operation
- All outputs are registered.
- **States:** IDLE, ADDR (BDIR=1, BC=1, bus_do={4'h0,addr}), GAP_A, WRITE (BDIR=1, BC=0, bus_do=wdata), READ (BDIR=0, BC=1), GAP_D. In both gap states BDIR=0 and BC=0.
- **Accept:** req_valid & req_ready sampled at a rising edge. req_addr, req_we and req_wdata are captured into internal registers at that edge. Host inputs are ignored until req_ready returns high.
- **Transitions:**
  - IDLE → ADDR, or directly to WRITE/READ on a cache hit.
  - ADDR → GAP_A after PULSE_LEN cycles.
  - GAP_A → WRITE or READ after GAP_LEN cycles.
  - WRITE or READ → GAP_D after PULSE_LEN cycles.
  - GAP_D → IDLE after GAP_LEN cycles.
- **Phase counter:** one 4-bit down-counter. It is loaded with PULSE_LEN-1 or GAP_LEN-1 on entry to a state, and the state exits at the cycle where the counter is 0.
- **Address cache:**
  - Holds a 4-bit cached address plus a cache_valid flag. Both are set at the end of every ADDR phase.
  - A hit requires cache_valid & (req_addr == cached) & ADDR_CACHE.
  - cache_valid is cleared by reset only.
- **Read capture:** bus_di is sampled into rd_data at the clock edge that ends the last READ cycle. rd_valid is high for exactly the following cycle, which is the first GAP_D cycle.
- **bus_do** is 8'h00 outside the ADDR and WRITE states.
- **req_ready** is high only in IDLE.

## Timing
- Cycle numbering: cycle n = n-th clock period after the accepting edge (n ≥ 1).
- **Full access** (no cache hit):
  - cycles 1..P: ADDR
  - cycles P+1..P+G: GAP_A
  - next P cycles: data phase
  - next G cycles: GAP_D
  - req_ready high in cycle 2P+2G+1
- **Cache hit:**
  - cycles 1..P: data phase
  - cycles P+1..P+G: GAP_D
  - req_ready high in cycle P+G+1
- **Back-to-back:** a request valid in the first IDLE cycle is accepted at that cycle's edge. There are no extra idle cycles beyond GAP_LEN.
- **Reset** (any state, mid-access included), effective on the next edge:
  - state IDLE, BDIR=0, BC=0, bus_do=0
  - rd_valid=0, rd_data=0
  - req_ready=1 in the first cycle after reset deasserts
  - cache_valid=0
  - An aborted access is lost and is not retried.
- **Simultaneous events:** req_valid together with RESET → the request is not accepted.

## Test plan
- **Write, no cache** (P=2, G=1), reg 7, data 0x38 → {BDIR,BC}:
  - cycles 1-2: 11 with bus_do=0x07
  - cycle 3: 00
  - cycles 4-5: 10 with bus_do=0x38
  - cycle 6: 00
  - req_ready high in cycle 7
  - a `ym2149` model then reads back 0x38 from reg 7
- **Read** reg 14, with the PSG returning 0x5A → {BDIR,BC}:
  - cycles 1-2: 11
  - cycle 3: 00
  - cycles 4-5: 01
  - cycle 6: rd_valid=1 and rd_data=0x5A
  - cycle 7: rd_valid=0, rd_data still 0x5A
- **Cache hit:** write reg 7 = 0x38, then write reg 7 = 0x3F →
  - second access has no ADDR phase: cycles 1-2 are 10 with bus_do=0x3F, cycle 3 is 00, req_ready high in cycle 4
  - repeat with ADDR_CACHE=0 → full 6-cycle access
- **Cache miss after hit:** write reg 7 → write reg 8 = 0x0F → the full sequence is issued with bus_do=0x08 in the ADDR phase.
- **Reset in WRITE cycle 4** of a full access → next cycle BDIR=BC=0, req_ready=1. A following write to reg 7 issues the ADDR phase, because the cache was invalidated.
- **Back-to-back random writes** to all 16 registers against the `ym2149` model → every register reads back the written value, and BDIR is low for ≥G cycles between every pair of assertions.

Source files
------------

// File: rtl/psg_bus_master.sv
// YM2149/AY-3-8910 bus initiator: turns valid/ready register requests into BDIR/BC
// latch/write/read cycles, with an optional cache that skips repeated address phases.
module psg_bus_master #(
  parameter int unsigned PULSE_LEN  = 2,
  parameter int unsigned GAP_LEN    = 1,
  parameter bit          ADDR_CACHE = 1'b1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [3:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       BDIR,
  output logic       BC,
  output logic [7:0] bus_do,
  input  logic [7:0] bus_di
);

  localparam logic [3:0] PulseM1 = 4'(PULSE_LEN - 1);
  localparam logic [3:0] GapM1   = 4'(GAP_LEN - 1);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StGapA,
    StWrite,
    StRead,
    StGapD
  } state_e;

  state_e     state_q;
  logic [3:0] cnt_q;
  logic [3:0] addr_q;
  logic       we_q;
  logic [7:0] wdata_q;
  logic [3:0] cache_addr_q;
  logic       cache_valid_q;
  logic       ready_q;
  logic       rd_valid_q;
  logic [7:0] rd_data_q;
  logic       bdir_q;
  logic       bc_q;
  logic [7:0] bus_do_q;

  logic       accept;
  logic       hit;
  logic       data_we;
  logic [7:0] data_wdata;

  always_comb begin
    accept     = (state_q == StIdle) && req_valid && ready_q;
    hit        = ADDR_CACHE && cache_valid_q && (req_addr == cache_addr_q);
    // The data phase is entered either straight from IDLE (cache hit) or from GAP_A.
    data_we    = (state_q == StIdle) ? req_we : we_q;
    data_wdata = (state_q == StIdle) ? req_wdata : wdata_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= StIdle;
      cnt_q         <= 4'd0;
      addr_q        <= 4'd0;
      we_q          <= 1'b0;
      wdata_q       <= 8'h00;
      cache_addr_q  <= 4'd0;
      cache_valid_q <= 1'b0;
      ready_q       <= 1'b1;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= 8'h00;
      bdir_q        <= 1'b0;
      bc_q          <= 1'b0;
      bus_do_q      <= 8'h00;
    end else begin
      rd_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            addr_q  <= req_addr;
            we_q    <= req_we;
            wdata_q <= req_wdata;
            ready_q <= 1'b0;
            cnt_q   <= PulseM1;
            if (hit) begin
              state_q  <= data_we ? StWrite : StRead;
              bdir_q   <= data_we;
              bc_q     <= ~data_we;
              bus_do_q <= data_we ? data_wdata : 8'h00;
            end else begin
              state_q  <= StAddr;
              bdir_q   <= 1'b1;
              bc_q     <= 1'b1;
              bus_do_q <= {4'h0, req_addr};
            end
          end
        end
        StAddr: begin
          if (cnt_q == 4'd0) begin
            state_q       <= StGapA;
            cnt_q         <= GapM1;
            bdir_q        <= 1'b0;
            bc_q          <= 1'b0;
            bus_do_q      <= 8'h00;
            cache_addr_q  <= addr_q;
            cache_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StGapA: begin
          if (cnt_q == 4'd0) begin
            state_q  <= data_we ? StWrite : StRead;
            cnt_q    <= PulseM1;
            bdir_q   <= data_we;
            bc_q     <= ~data_we;
            bus_do_q <= data_we ? data_wdata : 8'h00;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StWrite, StRead: begin
          if (cnt_q == 4'd0) begin
            state_q  <= StGapD;
            cnt_q    <= GapM1;
            bdir_q   <= 1'b0;
            bc_q     <= 1'b0;
            bus_do_q <= 8'h00;
            if (state_q == StRead) begin
              rd_data_q  <= bus_di;
              rd_valid_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StGapD: begin
          if (cnt_q == 4'd0) begin
            state_q <= StIdle;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign BDIR      = bdir_q;
  assign BC        = bc_q;
  assign bus_do    = bus_do_q;

endmodule
